// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encoding and the counter sizing function live here.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Number of bits needed to hold values 0..n-1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = unsigned'(i) + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b mod 2^WIDTH, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               brw_q, brw_d;
    logic               borrow_q, borrow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic fs_d;
    logic fs_bout;

    full_subtractor u_fs (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (brw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        part_d   = part_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                part_d = {fs_d, part_q[WIDTH-1:1]};
                brw_d  = fs_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                // Last bit: publish the whole result on this edge only.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    diff_d   = part_d;
                    borrow_d = fs_bout;
                    done_d   = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            part_q   <= part_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 Port: busy  output  1  high while bits are being processed.
REQ-008 Port: done  output  1  one-cycle pulse marking a valid new result.
REQ-009 Port: diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 Port: borrow  output  1  final borrow out; equals 1 iff a<b unsigned.
REQ-011 Port (only with SERIAL_SUB_OVF_EN): ovf  output  1  two's-complement signed overflow of a-b.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-013 start SHALL be accepted in IDLE or DONE only; on acceptance, a and b load into shift registers, the borrow register clears to 0, the bit counter clears to 0, and the state goes to SHIFT.
REQ-014 start in SHIFT SHALL be ignored, with no effect on the operation in progress.
REQ-015 Each SHIFT cycle SHALL compute one bit, LSB first: it passes the operand LSBs and the borrow register through one full subtractor, shifts the difference bit into the partial-result MSB, stores the borrow out, shifts the operands right, and increments the counter.
REQ-016 After exactly WIDTH SHIFT cycles, the FSM SHALL go to DONE and copy the partial result to diff, the final borrow to borrow, and (if enabled) the overflow to ovf, all on the same edge.
REQ-017 done SHALL be high for exactly one cycle, the cycle following the WIDTH-th edge after the accepting edge; the latency from accepting start to done is WIDTH cycles.
REQ-018 From DONE, the FSM SHALL go to IDLE, or to SHIFT if start is high on that edge (back-to-back operation with no bubble).
REQ-019 busy SHALL be high exactly when the state is SHIFT.
REQ-020 diff, borrow and ovf SHALL hold their last completed value until the next completion and SHALL never expose partial results.
REQ-021 Operands equal to 0 or all-ones SHALL need no special casing: 0-0 gives diff 0, borrow 0.

Reset
REQ-022 rst_n low SHALL, asynchronously, set the state to IDLE and clear busy, done, diff, borrow, ovf, the counter, the shift registers and the borrow register to 0.
REQ-023 Reset during SHIFT SHALL abandon the operation with no done pulse; after reset release, the next accepted start SHALL begin a fresh operation.

Configuration
REQ-024 Macro SERIAL_SUB_OVF_EN defined: the ovf port exists and is set at completion to (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the operands as latched.
REQ-025 Macro SERIAL_SUB_OVF_EN undefined: the ovf port, its register and the latched operand sign bits are absent; all other behaviour is identical.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the state encoding constants (IDLE, SHIFT, DONE) and the counter-width function clog2(WIDTH+1).
REQ-027 A sub-module full_subtractor SHALL compute d = x^y^bin and bout = (~x&y) | (~(x^y)&bin), and SHALL be instantiated once.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, start pulse -> done 8 cycles later, diff=0x02, borrow=0, busy high for 8 cycles.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, borrow=1; with the macro, ovf=0.
REQ-030 With the macro: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1.
REQ-031 start re-asserted with a=0xFF, b=0xFF at cycle 3 of a busy operation -> ignored; the original result is delivered unchanged.
REQ-032 rst_n pulsed low at cycle 4 of SHIFT -> all outputs 0 immediately, no done pulse; the next start with 0x10-0x01 gives 0x0F.
REQ-033 start held high in DONE with a=0x0A, b=0x0A -> a new operation starts with no IDLE cycle, and the second done gives diff=0x00, borrow=0.
